ysyx_210544_cmt_queue: RTL and testbench

//  Parametrised commit queue between writeback and the difftest commit unit. Buffers up
//  to DEPTH committed instructions (req/ack in, valid/ready out) so a stalled commit

---
 rtl/ysyx_210544_cmt_queue.sv | 93 +++++++++
 tb/tb_ysyx_210544_cmt_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_cmt_queue.sv
// ysyx_210544_cmt_queue: commit FIFO between writeback and difftest with cycle/instret counters.
// Define CMT_TRAP_DETECT_EN to latch the first trap instruction seen at the head.
module ysyx_210544_cmt_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int ILEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_wb_req,
  output logic                       o_wb_ack,
  input  logic [4:0]                 i_wb_rd,
  input  logic                       i_wb_rd_wen,
  input  logic [XLEN-1:0]            i_wb_rd_wdata,
  input  logic [XLEN-1:0]            i_wb_pc,
  input  logic [ILEN-1:0]            i_wb_inst,
  input  logic                       i_wb_nocmt,
  input  logic                       i_wb_skipcmt,
  input  logic [31:0]                i_wb_intrNo,
  output logic                       o_cmt_valid,
  input  logic                       i_cmt_ready,
  output logic [4:0]                 o_cmt_rd,
  output logic                       o_cmt_rd_wen,
  output logic [XLEN-1:0]            o_cmt_rd_wdata,
  output logic [XLEN-1:0]            o_cmt_pc,
  output logic [ILEN-1:0]            o_cmt_inst,
  output logic                       o_cmt_skipcmt,
  output logic [31:0]                o_cmt_intrNo,
  output logic [$clog2(DEPTH):0]     o_cmt_count,
  output logic [63:0]                o_cycle_cnt,
  output logic [63:0]                o_instret_cnt,
  output logic                       o_trap,
  output logic [7:0]                 o_trap_code
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            skip;
    logic [31:0]     intr;
  } ent_t;
  ent_t ram [DEPTH];
  ent_t head;
  logic [AW:0] wp, rp;
  logic empty, full, push, pop;
  assign empty       = wp == rp;
  assign full        = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign o_wb_ack    = !full;
  assign o_cmt_valid = !empty;
  assign push        = i_wb_req && o_wb_ack && !i_wb_nocmt;
  assign pop         = o_cmt_valid && i_cmt_ready;
  assign o_cmt_count = wp - rp;
  // Gate the RAM read so head fields read as zero whenever nothing is held
  assign head           = empty ? '0 : ram[rp[AW-1:0]];
  assign o_cmt_rd       = head.rd;
  assign o_cmt_rd_wen   = head.wen;
  assign o_cmt_rd_wdata = head.wdata;
  assign o_cmt_pc       = head.pc;
  assign o_cmt_inst     = head.inst;
  assign o_cmt_skipcmt  = head.skip;
  assign o_cmt_intrNo   = head.intr;
  always_ff @(posedge clk)
    if (push) ram[wp[AW-1:0]] <= '{i_wb_rd, i_wb_rd_wen, i_wb_rd_wdata, i_wb_pc, i_wb_inst, i_wb_skipcmt, i_wb_intrNo};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp            <= '0;
      rp            <= '0;
      o_cycle_cnt   <= '0;
      o_instret_cnt <= '0;
    end else begin
      wp            <= wp + (AW+1)'(push);
      rp            <= rp + (AW+1)'(pop);
      o_cycle_cnt   <= o_cycle_cnt + 64'd1;
      o_instret_cnt <= o_instret_cnt + 64'(pop && !head.skip);
    end
`ifdef CMT_TRAP_DETECT_EN
  // First trap wins; the code stays sticky until reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_trap      <= 1'b0;
      o_trap_code <= '0;
    end else if (pop && !o_trap && head.inst == ILEN'(32'h0000006b)) begin
      o_trap      <= 1'b1;
      o_trap_code <= head.wdata[7:0];
    end
`else
  assign o_trap      = 1'b0;
  assign o_trap_code = '0;
`endif
endmodule

// File: tb/tb_ysyx_210544_cmt_queue.sv
// tb_ysyx_210544_cmt_queue: directed stimulus checked against a queue-based commit model.
module tb_ysyx_210544_cmt_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic [31:0] intr;
  } ent_t;
  logic clk = 0, rst = 0;
  logic req = 0, nocmt = 0, skip = 0, wen = 0, ready = 0;
  logic [4:0] rd = 0;
  logic [63:0] wdata = 0, pc = 0;
  logic [31:0] inst = 0, intr = 0;
  logic ack, valid, c_wen, c_skip, trap;
  logic [4:0] c_rd;
  logic [63:0] c_wdata, c_pc, cyc_cnt, ret_cnt;
  logic [31:0] c_inst, c_intr;
  logic [2:0] count;
  logic [7:0] code;
  int n_chk = 0, n_fail = 0;
  ent_t mq[$];
  ent_t h;
  logic [63:0] m_cyc = 0, m_ret = 0;
  logic m_trap = 0, m_pop, m_push;
  logic [7:0] m_code = 0;
  ysyx_210544_cmt_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_wb_req(req), .o_wb_ack(ack), .i_wb_rd(rd), .i_wb_rd_wen(wen),
    .i_wb_rd_wdata(wdata), .i_wb_pc(pc), .i_wb_inst(inst), .i_wb_nocmt(nocmt),
    .i_wb_skipcmt(skip), .i_wb_intrNo(intr), .o_cmt_valid(valid), .i_cmt_ready(ready),
    .o_cmt_rd(c_rd), .o_cmt_rd_wen(c_wen), .o_cmt_rd_wdata(c_wdata), .o_cmt_pc(c_pc),
    .o_cmt_inst(c_inst), .o_cmt_skipcmt(c_skip), .o_cmt_intrNo(c_intr), .o_cmt_count(count),
    .o_cycle_cnt(cyc_cnt), .o_instret_cnt(ret_cnt), .o_trap(trap), .o_trap_code(code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: an ideal FIFO of committed entries plus counters, advanced on each clock
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_cyc = 0; m_ret = 0; m_trap = 0; m_code = 0;
    end else begin
      m_pop  = mq.size() > 0 && ready;
      m_push = req && mq.size() < DEPTH && !nocmt;
      if (m_pop) begin
        if (!mq[0].skip) m_ret++;
`ifdef CMT_TRAP_DETECT_EN
        if (mq[0].inst == 32'h6b && !m_trap) begin m_trap = 1; m_code = mq[0].wdata[7:0]; end
`endif
        void'(mq.pop_front());
      end
      if (m_push) mq.push_back('{rd, wen, wdata, pc, inst, skip, intr});
      m_cyc++;
    end
  end
  initial forever begin
    @(negedge clk);
    h = mq.size() > 0 ? mq[0] : '0;
    chk("ack", ack, 64'(mq.size() < DEPTH));
    chk("valid", valid, 64'(mq.size() > 0));
    chk("count", count, 64'(mq.size()));
    chk("head_pc", c_pc, h.pc);
    chk("head_inst", c_inst, h.inst);
    chk("head_rd", c_rd, h.rd);
    chk("head_wen", c_wen, h.wen);
    chk("head_wdata", c_wdata, h.wdata);
    chk("head_skip", c_skip, h.skip);
    chk("head_intr", c_intr, h.intr);
    chk("cycle_cnt", cyc_cnt, m_cyc);
    chk("instret", ret_cnt, m_ret);
    chk("trap", trap, m_trap);
    chk("trap_code", code, m_code);
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic offer(input logic [63:0] p, input logic [31:0] in, input logic [63:0] wd,
                       input logic sk, input logic nc);
    req = 1; pc = p; inst = in; wdata = wd; skip = sk; nocmt = nc;
    rd = p[6:2]; wen = p[2]; intr = 32'(p[3:0]);
    cyc();
    req = 0; nocmt = 0; skip = 0;
  endtask
  initial begin
    int tries;
    logic acc;
    idle(2);
    chk("rst_valid", valid, 0);
    chk("rst_count", count, 0);
    chk("rst_cycle", cyc_cnt, 0);
    chk("rst_trap", trap, 0);
    rst = 1;
    chk("rst_ack", ack, 1);
    ready = 1;
    offer(64'h80000000, 32'h13, 64'h11, 0, 0);
    chk("t1_head_pc", c_pc, 64'h80000000);
    offer(64'h80000004, 32'h93, 64'h22, 0, 0);
    offer(64'h80000008, 32'h113, 64'h33, 0, 0);
    idle(3);
    chk("t1_count", count, 0);
    chk("t1_instret", ret_cnt, 3);
    ready = 0;
    for (int i = 0; i < 4; i++) offer(64'h100 + 64'(4 * i), 32'h1000 + i, 64'(i), 0, 0);
    chk("t2_count_full", count, 4);
    chk("t2_ack_full", ack, 0);
    offer(64'h200, 32'h2000, 64'h5, 0, 0);
    chk("t2_fifth_refused", count, 4);
    chk("t2_head_pc", c_pc, 64'h100);
    ready = 1;
    idle(4);
    chk("t2_count_empty", count, 0);
    chk("t2_ack_back", ack, 1);
    chk("t2_instret", ret_cnt, 7);
    ready = 0;
    for (int i = 0; i < 4; i++) offer(64'h300 + 64'(4 * i), 32'h3000 + i, 64'(i), 0, 0);
    ready = 1;
    offer(64'h340, 32'h3040, 64'h40, 0, 0);
    chk("t3_push_refused", count, 3);
    ready = 0;
    offer(64'h344, 32'h3044, 64'h44, 0, 0);
    chk("t3_push_accepted", count, 4);
    chk("t3_head_pc", c_pc, 64'h304);
    ready = 1;
    idle(5);
    chk("t3_instret", ret_cnt, 12);
    for (int i = 0; i < 6; i++) begin
      chk("t4_ack", ack, 1);
      offer(64'h400 + 64'(4 * i), 32'h4000 + i, 64'(i), i == 3, i % 2 == 0);
    end
    idle(3);
    chk("t4_count", count, 0);
    chk("t4_instret", ret_cnt, 14);
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        req = 1; pc = 64'h500 + 64'(4 * i); inst = 32'h5000 + i; wdata = 64'(i * 3);
        rd = 5'(i); wen = i[0]; intr = 0;
        acc = ack;
        ready = ~ready;
        cyc();
        tries++;
      end while (!acc && tries < 20);
      if (!acc) begin
        n_chk++; n_fail++;
        $display("FAIL t5_timeout: entry %0d never accepted", i);
      end
    end
    req = 0; ready = 1;
    idle(6);
    chk("t5_count", count, 0);
    chk("t5_instret", ret_cnt, 24);
    offer(64'h600, 32'h0000006b, 64'h0, 0, 0);
    idle(2);
`ifdef CMT_TRAP_DETECT_EN
    chk("t6_trap", trap, 1);
`else
    chk("t6_trap", trap, 0);
`endif
    chk("t6_code", code, 0);
    ready = 0;
    offer(64'h700, 32'h7000, 64'h7, 0, 0);
    offer(64'h704, 32'h7004, 64'h8, 0, 0);
    chk("t6_count_pre", count, 2);
    rst = 0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_trap", trap, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_cycle", cyc_cnt, 0);
    chk("t6_rst_instret", ret_cnt, 0);
    idle(2);
    rst = 1; ready = 1;
    idle(3);
    chk("t6_no_commit", valid, 0);
    chk("t6_instret_after", ret_cnt, 0);
    chk("t6_cycle_after", cyc_cnt, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
